// File: rtl/rr_bus_arbiter_pkg.sv
// rr_bus_arbiter_pkg: shared state enum, requester count and index types for the arbiter
package rr_bus_arbiter_pkg;
  localparam int N_REQ = 4;
  localparam int TENURE_W = 8;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
  typedef logic [$clog2(N_REQ)-1:0] owner_t;
  typedef logic [TENURE_W-1:0] tenure_t;
endpackage

// File: rtl/rr_bus_arbiter_pick.sv
// rr_pick: combinational round-robin search, first raised request at or after ptr (wrapping)
module rr_pick
  import rr_bus_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  owner_t           ptr,
  output logic             valid,
  output owner_t           idx
);
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[ptr + owner_t'(i)]) idx = ptr + owner_t'(i);
    valid = |req;
  end
endmodule

// File: rtl/rr_bus_arbiter.sv
// rr_bus_arbiter: round-robin bus arbiter with a one-cycle turnaround gap and a MAX_HOLD tenure limit
module rr_bus_arbiter #(
  parameter int MAX_HOLD = 16,
  parameter int N_REQ = rr_bus_arbiter_pkg::N_REQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       owner,
  output logic             busy,
  output logic             timeout
);
  import rr_bus_arbiter_pkg::*;
  state_t state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  owner_t owner_q, owner_d, ptr_q, ptr_d, pick_idx;
  tenure_t tenure_q, tenure_d;
  logic busy_q, busy_d, timeout_q, timeout_d, pick_valid, release_w, expire_w;
  rr_pick u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );
  assign release_w = done[owner_q] | ~req[owner_q];
  assign expire_w  = tenure_q == tenure_t'(MAX_HOLD - 1);
  // a release on the expiry cycle wins, so timeout only flags a forced revoke
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tenure_d  = tenure_q;
    timeout_d = 1'b0;
    if (state_q == GRANT) begin
      if (release_w || expire_w) begin
        state_d   = GAP;
        gnt_d     = '0;
        timeout_d = ~release_w;
      end else tenure_d = tenure_q + tenure_t'(1);
    end else if (pick_valid) begin
      state_d  = GRANT;
      gnt_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
      owner_d  = pick_idx;
      ptr_d    = pick_idx + owner_t'(1);
      tenure_d = '0;
    end else state_d = IDLE;
    busy_d = |gnt_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tenure_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tenure_q  <= tenure_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end
  assign gnt     = gnt_q;
  assign owner   = owner_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;
endmodule

// File: doc/rr_bus_arbiter.md
RR_BUS_ARBITER -- requirements
Module: rr_bus_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum number of consecutive cycles one owner may hold the grant (legal range 2..255).
REQ-002 Parameter N_REQ, default 4, is the number of requesters; fixed at 4 in this revision.
REQ-003 clk  input  1  is the single clock; all state updates on posedge clk.
REQ-004 rst  input  1  is the reset: asynchronous, active-high.
REQ-005 req  input  4  is the per-requester request level, held high while access is wanted.
REQ-006 done  input  4  is the per-requester release strobe; only done[owner] is honoured.
REQ-007 gnt  output  4  is the registered one-hot grant, or all-zero.
REQ-008 owner  output  2  is the index of the current grant holder; valid only while busy=1.
REQ-009 busy  output  1  is high exactly when gnt is non-zero.
REQ-010 timeout  output  1  is a one-cycle pulse when a grant is revoked by MAX_HOLD expiry.

Function
REQ-011 The FSM SHALL have three states: IDLE (no grant), GRANT (one owner), GAP (one-cycle turnaround, no grant).
REQ-012 All outputs SHALL be registered; gnt SHALL never have more than one bit set.
REQ-013 In IDLE or GAP with req!=0 at edge n, the block SHALL enter GRANT with gnt one-hot to the picked requester from cycle n+1 (latency 1).
REQ-014 In IDLE or GAP with req==0, the next state SHALL be IDLE.
REQ-015 Pick rule: round-robin, searching ascending (wrap 3->0) from index ptr; the first requester with req high wins.
REQ-016 On every grant, ptr SHALL load (winner+1) mod 4; on wrap, 3+1 yields 0.
REQ-017 In GRANT, if done[owner]=1 or req[owner]=0 at an edge, the next state SHALL be GAP and gnt SHALL be 0 in the following cycle.
REQ-018 A tenure counter SHALL clear on grant and increment each GRANT cycle.
REQ-019 When the counter reaches MAX_HOLD-1 without release, the next state SHALL be GAP and timeout SHALL pulse high for exactly that GAP cycle.
REQ-020 If release and expiry coincide, the release SHALL take priority and timeout SHALL stay 0.
REQ-021 done bits of non-owners, and done while not in GRANT, SHALL be ignored.
REQ-022 Requests from non-owners SHALL never pre-empt the owner.
REQ-023 gnt SHALL be low for exactly one cycle between consecutive owners, including when the same requester is re-granted.
REQ-024 owner SHALL hold its last value in IDLE and GAP.
REQ-025 Under continuous requests, no requester SHALL wait more than 3 tenures.

Reset
REQ-026 On rst high, the block SHALL immediately and asynchronously set: state=IDLE, gnt=0, owner=0, busy=0, timeout=0, ptr=0, tenure=0.
REQ-027 Reset asserted mid-GRANT SHALL drop gnt without passing through GAP and without a timeout pulse.
REQ-028 After rst deasserts, the first arbitration SHALL give requester 0 highest priority.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, GRANT, GAP), the N_REQ constant and the owner-index typedef.
REQ-030 The round-robin search SHALL be a combinational sub-module, rr_pick (inputs req, ptr; outputs valid, idx).
REQ-031 The FSM, tenure counter and ptr register SHALL live in rr_bus_arbiter.

Verification
REQ-032 Reset then req=4'b0110 at cycle 0 -> gnt=4'b0010, owner=1 at cycle 1; after done[1] pulse, gnt=0 one cycle, then gnt=4'b0100.
REQ-033 req=4'b1111 held with done pulsed on the 3rd cycle of each tenure -> grant order 0,1,2,3,0, with one idle cycle between each.
REQ-034 MAX_HOLD=4, req0 held, done never asserted -> gnt0 high exactly 4 cycles, then gnt=0 with timeout=1 for 1 cycle, then gnt0 re-granted.
REQ-035 done[owner] asserted on the expiry cycle -> GAP entered, timeout stays 0.
REQ-036 rst pulsed mid-tenure of owner 2 -> gnt=0 immediately; after release, req=4'b1100 yields gnt=4'b0100 (ptr back at 0).
REQ-037 done[3] pulsed while owner=1, and req[2] raised during the tenure -> owner 1 keeps the grant, no state change.
